// File: rtl/mem_arb_pkg.sv
// Shared widths, limits and lock state type for the memory arbiter.
// Optional bus locking is built when MEM_ARB_LOCK_EN is defined.
package mem_arb_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 12;
  localparam int MAX_CORES  = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr,
// searched cyclically, returned one-hot and as an index.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = MAX_CORES,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          found
);

  logic [PW-1:0] j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 1; i <= N; i++) begin
      j = PW'((int'(ptr) + i) % N);
      if (!found && elig[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared single-port memory.
// Define MEM_ARB_LOCK_EN to add lock_i for atomic multi-access sequences.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = MAX_CORES,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int ADDR_W    = MEM_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        we_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]        lock_i,
`endif
  output logic [NUM_CORES-1:0]        gnt_o,
  output logic [NUM_CORES-1:0]        rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_din_o,
  input  logic [DATA_W-1:0]           mem_dout_i
);

  localparam int PW = $clog2(NUM_CORES);

  logic [PW-1:0]        ptr;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] win;
  logic [PW-1:0]        win_idx;
  logic                 found;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_din;
  logic                 sel_we;

  assign rdata_o = mem_dout_i;

`ifdef MEM_ARB_LOCK_EN
  lock_state_t          lock_q;
  logic [NUM_CORES-1:0] owner;
  logic                 lock_hold;
  logic                 win_lock;

  // While locked, ptr is the owner; only it may win until it drops lock_i.
  always_comb begin
    owner      = '0;
    owner[ptr] = 1'b1;
    lock_hold  = (lock_q == LOCKED) && lock_i[ptr];
    win_lock   = |(lock_i & win);
    elig       = req_i & ~gnt_o;
    if (lock_hold)
      elig = elig & owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= UNLOCKED;
    end else begin
      unique case (1'b1)
        found:      lock_q <= win_lock ? LOCKED : UNLOCKED;
        !lock_hold: lock_q <= UNLOCKED;
        default:    lock_q <= lock_q;
      endcase
    end
  end
`else
  assign elig = req_i & ~gnt_o;
`endif

  rr_pick #(
    .N  (NUM_CORES),
    .PW (PW)
  ) u_pick (
    .elig    (elig),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (win[k]) begin
        sel_addr = addr_i[k*ADDR_W +: ADDR_W];
        sel_din  = wdata_i[k*DATA_W +: DATA_W];
        sel_we   = we_i[k];
      end
    end
  end

  // The memory loads dout on the edge after the grant, so rvalid follows gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_o      <= '0;
      rvalid_o   <= '0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_din_o  <= '0;
      ptr        <= PW'(NUM_CORES - 1);
    end else begin
      rvalid_o <= gnt_o & {NUM_CORES{~mem_we_o}};
      if (found) begin
        gnt_o      <= win;
        mem_addr_o <= sel_addr;
        mem_din_o  <= sel_din;
        mem_we_o   <= sel_we;
        ptr        <= win_idx;
      end else begin
        gnt_o    <= '0;
        mem_we_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural memory.
// Lock sequence is exercised when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  we;
    logic [7:0]  gnt;
    logic        mwe;
    logic [7:0]  rv;
    logic [15:0] rdata;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   req = '0;
  logic [7:0]   we = '0;
  logic [11:0]  core_addr [8];
  logic [15:0]  core_wdata [8];
  logic [95:0]  addr_bus;
  logic [127:0] wdata_bus;
  logic [7:0]   gnt;
  logic [7:0]   rv;
  logic [15:0]  rdata;
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [15:0]  mem_din;
  logic [15:0]  mem_dout = '0;
  logic [15:0]  mem [4096];
`ifdef MEM_ARB_LOCK_EN
  logic [7:0]   lock = '0;
`endif

  int total = 0;
  int bad = 0;
  vec_t tv [24];
  logic [11:0] ea;
  logic [15:0] ed;

  always #5 clk = ~clk;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int k = 0; k < 8; k++) begin
      addr_bus[k*12 +: 12]  = core_addr[k];
      wdata_bus[k*16 +: 16] = core_wdata[k];
    end
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr_bus),
    .wdata_i    (wdata_bus),
`ifdef MEM_ARB_LOCK_EN
    .lock_i     (lock),
`endif
    .gnt_o      (gnt),
    .rvalid_o   (rv),
    .rdata_o    (rdata),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] w);
    @(negedge clk);
    req = r;
    we  = w;
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2i(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    for (int k = 0; k < 8; k++) begin
      core_addr[k]  = 12'h100 + 12'(k);
      core_wdata[k] = 16'hA000 + 16'(k);
      mem[12'h100 + 12'(k)] <= 16'h5000 + 16'(k);
    end

    tv[0]  = '{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 16'h0000};
    tv[1]  = '{8'hFE, 8'h00, 8'h02, 1'b0, 8'h01, 16'h5000};
    tv[2]  = '{8'hFC, 8'h00, 8'h04, 1'b0, 8'h02, 16'h5001};
    tv[3]  = '{8'hF8, 8'h00, 8'h08, 1'b0, 8'h04, 16'h5002};
    tv[4]  = '{8'hF0, 8'h00, 8'h10, 1'b0, 8'h08, 16'h5003};
    tv[5]  = '{8'hE0, 8'h00, 8'h20, 1'b0, 8'h10, 16'h5004};
    tv[6]  = '{8'hC0, 8'h00, 8'h40, 1'b0, 8'h20, 16'h5005};
    tv[7]  = '{8'h80, 8'h00, 8'h80, 1'b0, 8'h40, 16'h5006};
    tv[8]  = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h80, 16'h5007};
    tv[9]  = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
    tv[10] = '{8'h20, 8'h00, 8'h20, 1'b0, 8'h00, 16'h0000};
    tv[11] = '{8'h20, 8'h00, 8'h00, 1'b0, 8'h20, 16'h5005};
    tv[12] = '{8'h20, 8'h00, 8'h20, 1'b0, 8'h00, 16'h0000};
    tv[13] = '{8'h20, 8'h00, 8'h00, 1'b0, 8'h20, 16'h5005};
    tv[14] = '{8'h20, 8'h00, 8'h20, 1'b0, 8'h00, 16'h0000};
    tv[15] = '{8'h20, 8'h00, 8'h00, 1'b0, 8'h20, 16'h5005};
    tv[16] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
    tv[17] = '{8'h08, 8'h08, 8'h08, 1'b1, 8'h00, 16'h0000};
    tv[18] = '{8'h42, 8'h00, 8'h40, 1'b0, 8'h00, 16'h0000};
    tv[19] = '{8'h02, 8'h00, 8'h02, 1'b0, 8'h40, 16'h5006};
    tv[20] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h02, 16'h5001};
    tv[21] = '{8'h03, 8'h03, 8'h01, 1'b1, 8'h00, 16'h0000};
    tv[22] = '{8'h02, 8'h02, 8'h02, 1'b1, 8'h00, 16'h0000};
    tv[23] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};

    // Reset values
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(rv), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write must block it
    step(8'h01, 8'h01);
    chk("mid_gnt", 32'(gnt), 32'h01);
    chk("mid_we", 32'(mem_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'h0);
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_rv", 32'(rv), 32'h0);
    @(negedge clk);
    req = '0;
    we  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_nowrite", 32'(mem[12'h100]), 32'h5000);

    // Table: round-robin, grant masking, pointer contention, writes
    ea = '0;
    ed = '0;
    for (int i = 0; i < 24; i++) begin
      step(tv[i].req, tv[i].we);
      chk($sformatf("gnt_%0d", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("we_%0d", i), 32'(mem_we), 32'(tv[i].mwe));
      chk($sformatf("rv_%0d", i), 32'(rv), 32'(tv[i].rv));
      if (tv[i].gnt != 0) begin
        ea = 12'h100 + 12'(oh2i(tv[i].gnt));
        ed = 16'hA000 + 16'(oh2i(tv[i].gnt));
      end
      chk($sformatf("addr_%0d", i), 32'(mem_addr), 32'(ea));
      chk($sformatf("din_%0d", i), 32'(mem_din), 32'(ed));
      if (tv[i].rv != 0)
        chk($sformatf("rdata_%0d", i), 32'(rdata), 32'(tv[i].rdata));
    end
    chk("mem_103", 32'(mem[12'h103]), 32'hA003);
    chk("mem_100", 32'(mem[12'h100]), 32'hA000);
    chk("mem_101", 32'(mem[12'h101]), 32'hA001);

    // Core 2 writes 1234 to 0FA then reads it back
    core_addr[2]  = 12'h0FA;
    core_wdata[2] = 16'h1234;
    step(8'h04, 8'h04);
    chk("wr_gnt", 32'(gnt), 32'h04);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h0FA);
    chk("wr_din", 32'(mem_din), 32'h1234);
    step(8'h00, 8'h00);
    chk("wr_gnt_off", 32'(gnt), 32'h0);
    chk("wr_we_off", 32'(mem_we), 32'h0);
    step(8'h04, 8'h00);
    chk("rd_gnt", 32'(gnt), 32'h04);
    chk("rd_we", 32'(mem_we), 32'h0);
    step(8'h00, 8'h00);
    chk("rd_gnt_off", 32'(gnt), 32'h0);
    chk("rd_rv", 32'(rv), 32'h04);
    chk("rd_data", 32'(rdata), 32'h1234);
    core_addr[2]  = 12'h102;
    core_wdata[2] = 16'hA002;

`ifdef MEM_ARB_LOCK_EN
    // Core 4 locks the bus while core 0 waits
    lock = 8'h10;
    step(8'h11, 8'h00);
    chk("lk_gnt0", 32'(gnt), 32'h10);
    step(8'h11, 8'h00);
    chk("lk_gnt1", 32'(gnt), 32'h00);
    step(8'h11, 8'h00);
    chk("lk_gnt2", 32'(gnt), 32'h10);
    lock = 8'h00;
    step(8'h11, 8'h00);
    chk("lk_gnt3", 32'(gnt), 32'h01);
    step(8'h00, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
